crc_packer: RTL and testbench

CRC_PACKER -- requirements
Module: crc_packer

---
 rtl/crc_pkg.sv | 19 +
 rtl/crc8_byte_update.sv | 21 ++
 rtl/crc_packer.sv | 117 +++++++++++
 tb/tb_crc_packer.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/crc_pkg.sv
// Shared types and defaults for the CRC-8 byte packer.
package crc_pkg;

  localparam int unsigned LANES  = 4;
  localparam int unsigned LANE_W = 2;
  localparam int unsigned BYTE_W = 8;
  localparam int unsigned WORD_W = LANES * BYTE_W;

  localparam logic [7:0] CRC_POLY_DEF = 8'h07;
  localparam logic [7:0] CRC_INIT_DEF = 8'h00;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCUM  = 2'd1,
    APPEND = 2'd2,
    FLUSH  = 2'd3
  } state_t;

endpackage

// File: rtl/crc8_byte_update.sv
// One-byte CRC-8 update: MSB-first, non-reflected, no final XOR.
module crc8_byte_update #(
  parameter logic [7:0] CRC_POLY = 8'h07
) (
  input  logic [7:0] crc,
  input  logic [7:0] data,
  output logic [7:0] crc_next
);

  logic [7:0] acc;

  always_comb begin
    acc = crc ^ data;
    for (int i = 0; i < 8; i++) begin
      if (acc[7]) acc = {acc[6:0], 1'b0} ^ CRC_POLY;
      else        acc = {acc[6:0], 1'b0};
    end
    crc_next = acc;
  end

endmodule

// File: rtl/crc_packer.sv
// Packs a byte stream into little-endian 32-bit words and appends a CRC-8
// byte after the last payload byte of each frame.
module crc_packer
  import crc_pkg::*;
#(
  parameter logic [7:0] CRC_POLY = CRC_POLY_DEF,
  parameter logic [7:0] CRC_INIT = CRC_INIT_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  byte_i,
  input  logic        byte_valid_i,
  input  logic        byte_last_i,
  output logic        byte_ready_o,
  output logic [31:0] data_o,
  output logic [3:0]  we_o,
  input  logic        word_ready_i,
  output logic [7:0]  crc_o,
  output logic        crc_valid_o,
  output logic        busy_o
);

  state_t              state, next_state;
  logic [LANE_W-1:0]   lane;
  logic [7:0]          crc, crc_upd;
  logic [WORD_W-1:0]   acc;
  logic [WORD_W-1:0]   crc_word;
  logic [LANES-1:0]    crc_we;
  logic                word_free, accept, load_full, load_crc, take_flush;

  crc8_byte_update #(.CRC_POLY(CRC_POLY)) u_crc (
    .crc      (crc),
    .data     (byte_i),
    .crc_next (crc_upd)
  );

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  // Next-state logic
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (accept) next_state = byte_last_i ? APPEND : ACCUM;
      ACCUM:   if (accept && byte_last_i) next_state = APPEND;
      APPEND:  if (load_crc) next_state = FLUSH;
      FLUSH:   if (take_flush) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Handshake and control decode
  always_comb begin
    word_free    = (we_o == 4'h0) || word_ready_i;
    byte_ready_o = 1'b0;
    load_crc     = 1'b0;
    take_flush   = 1'b0;
    case (state)
      IDLE, ACCUM: byte_ready_o = !reset && word_free;
      APPEND:      load_crc     = word_free;
      FLUSH:       take_flush   = word_ready_i;
      default:     ;
    endcase
    accept    = byte_valid_i && byte_ready_o;
    load_full = accept && (lane == LANE_W'(LANES - 1));
    busy_o    = (state != IDLE);
  end

  // CRC word: filled payload lanes, CRC in the next free lane, zeros above
  always_comb begin
    crc_word = '0;
    crc_we   = '0;
    for (int k = 0; k < LANES; k++) begin
      if (LANE_W'(k) < lane)       crc_word[8*k +: 8] = acc[8*k +: 8];
      else if (LANE_W'(k) == lane) crc_word[8*k +: 8] = crc;
      crc_we[k] = (LANE_W'(k) <= lane);
    end
  end

  // Datapath: lane assembly, running CRC and output word register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lane        <= '0;
      crc         <= CRC_INIT;
      acc         <= '0;
      data_o      <= '0;
      we_o        <= '0;
      crc_o       <= '0;
      crc_valid_o <= 1'b0;
    end else begin
      crc_valid_o <= take_flush;
      if (accept) begin
        crc                  <= crc_upd;
        lane                 <= lane + LANE_W'(1);
        acc[{lane, 3'b000} +: 8] <= byte_i;
      end
      if (take_flush) begin
        crc   <= CRC_INIT;
        lane  <= '0;
        crc_o <= crc;
      end
      if (load_full) begin
        data_o <= {byte_i, acc[23:0]};
        we_o   <= 4'hF;
      end else if (load_crc) begin
        data_o <= crc_word;
        we_o   <= crc_we;
      end else if (word_ready_i) begin
        we_o   <= 4'h0;
      end
    end
  end

endmodule

// File: tb/tb_crc_packer.sv
// Directed-vector bench for crc_packer: framing, CRC append, stalls, reset.
module tb_crc_packer;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  byte_i;
  logic        byte_valid_i;
  logic        byte_last_i;
  logic        byte_ready_o;
  logic [31:0] data_o;
  logic [3:0]  we_o;
  logic        word_ready_i;
  logic [7:0]  crc_o;
  logic        crc_valid_o;
  logic        busy_o;

  int vectors = 0;
  int miscompares = 0;

  logic [7:0]  tx_b[$];
  logic        tx_l[$];
  logic [31:0] word_q[$];
  logic [3:0]  we_q[$];
  logic [7:0]  crc_q[$];

  crc_packer dut (
    .clk          (clk),
    .reset        (reset),
    .byte_i       (byte_i),
    .byte_valid_i (byte_valid_i),
    .byte_last_i  (byte_last_i),
    .byte_ready_o (byte_ready_o),
    .data_o       (data_o),
    .we_o         (we_o),
    .word_ready_i (word_ready_i),
    .crc_o        (crc_o),
    .crc_valid_o  (crc_valid_o),
    .busy_o       (busy_o)
  );

  always #5 clk = ~clk;

  // Record taken words and CRC pulses away from the active edge
  always @(negedge clk) begin
    if (!reset && we_o != 4'h0 && word_ready_i) begin
      word_q.push_back(data_o);
      we_q.push_back(we_o);
    end
    if (crc_valid_o) crc_q.push_back(crc_o);
  end

  task automatic clear_logs();
    word_q.delete(); we_q.delete(); crc_q.delete();
  endtask

  task automatic add_frame(input logic [7:0] b0, input int n);
    for (int i = 0; i < n; i++) begin
      tx_b.push_back(b0 + 8'(i));
      tx_l.push_back(i == n - 1);
    end
  endtask

  // Drive queued bytes with valid held high across bytes and frames
  task automatic send_tx();
    for (int i = 0; i < tx_b.size(); i++) begin
      bit ok;
      byte_valid_i = 1'b1;
      byte_i       = tx_b[i];
      byte_last_i  = tx_l[i];
      ok = 1'b0;
      for (int c = 0; c < 200 && !ok; c++) begin
        @(negedge clk);
        ok = byte_ready_o;
        @(posedge clk); #1;
      end
      if (!ok) begin
        vectors++; miscompares++;
        $display("FAIL send_timeout byte %0d not accepted", i);
      end
    end
    byte_valid_i = 1'b0;
    byte_last_i  = 1'b0;
    tx_b.delete(); tx_l.delete();
  endtask

  task automatic wait_crc(input int n);
    for (int c = 0; c < 200 && crc_q.size() < n; c++) begin
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    vectors++;
    if (crc_q.size() !== n) begin
      miscompares++;
      $display("FAIL crc_pulses got %0d want %0d", crc_q.size(), n);
    end
  endtask

  task automatic check_word(input int idx, input logic [31:0] d, input logic [3:0] w);
    vectors++;
    if (idx >= word_q.size()) begin
      miscompares++;
      $display("FAIL word%0d missing (only %0d words)", idx, word_q.size());
    end else if (word_q[idx] !== d || we_q[idx] !== w) begin
      miscompares++;
      $display("FAIL word%0d got %h/%b want %h/%b", idx, word_q[idx], we_q[idx], d, w);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; byte_valid_i = 1'b1; byte_i = 8'hAA; byte_last_i = 1'b0;
    word_ready_i = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    vectors++;
    if (data_o !== 32'h0 || we_o !== 4'h0) begin
      miscompares++; $display("FAIL reset_word got %h/%b want 0/0", data_o, we_o);
    end
    vectors++;
    if (crc_o !== 8'h00 || crc_valid_o !== 1'b0) begin
      miscompares++; $display("FAIL reset_crc got %h/%b want 00/0", crc_o, crc_valid_o);
    end
    vectors++;
    if (busy_o !== 1'b0 || byte_ready_o !== 1'b0) begin
      miscompares++; $display("FAIL reset_ctl busy %b ready %b want 0/0", busy_o, byte_ready_o);
    end
    byte_valid_i = 1'b0;
    @(negedge clk) reset = 1'b0;
    @(posedge clk); #1;
    vectors++;
    if (byte_ready_o !== 1'b1) begin
      miscompares++; $display("FAIL idle_ready got %b want 1", byte_ready_o);
    end
  endtask

  task automatic test_frame3();
    clear_logs();
    add_frame(8'h01, 3);
    send_tx();
    wait_crc(1);
    check_word(0, 32'h48030201, 4'hF);
    vectors++;
    if (word_q.size() !== 1 || crc_o !== 8'h48) begin
      miscompares++; $display("FAIL frame3 words %0d crc %h want 1/48", word_q.size(), crc_o);
    end
    vectors++;
    if (busy_o !== 1'b0) begin
      miscompares++; $display("FAIL frame3_busy got %b want 0", busy_o);
    end
  endtask

  task automatic test_frame4();
    clear_logs();
    add_frame(8'h01, 4);
    send_tx();
    wait_crc(1);
    check_word(0, 32'h04030201, 4'hF);
    check_word(1, 32'h000000E3, 4'b0001);
    vectors++;
    if (crc_o !== 8'hE3) begin
      miscompares++; $display("FAIL frame4_crc got %h want e3", crc_o);
    end
  endtask

  task automatic test_check_string();
    clear_logs();
    add_frame(8'h31, 9);
    send_tx();
    wait_crc(1);
    check_word(0, 32'h34333231, 4'hF);
    check_word(1, 32'h38373635, 4'hF);
    check_word(2, 32'h0000F439, 4'b0011);
    vectors++;
    if (crc_o !== 8'hF4) begin
      miscompares++; $display("FAIL check_crc got %h want f4", crc_o);
    end
  endtask

  task automatic test_stall();
    clear_logs();
    word_ready_i = 1'b0;
    add_frame(8'h01, 1);
    send_tx();
    @(negedge clk);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      vectors++;
      if (data_o !== 32'h00000701 || we_o !== 4'b0011 || byte_ready_o !== 1'b0 ||
          crc_valid_o !== 1'b0) begin
        miscompares++;
        $display("FAIL stall_c%0d data %h we %b ready %b cv %b want 00000701/0011/0/0",
                 c, data_o, we_o, byte_ready_o, crc_valid_o);
      end
    end
    @(posedge clk); #1;
    word_ready_i = 1'b1;
    wait_crc(1);
    check_word(0, 32'h00000701, 4'b0011);
    vectors++;
    if (crc_o !== 8'h07) begin
      miscompares++; $display("FAIL stall_crc got %h want 07", crc_o);
    end
  endtask

  task automatic test_reset_mid();
    clear_logs();
    tx_b.push_back(8'h01); tx_l.push_back(1'b0);
    tx_b.push_back(8'h02); tx_l.push_back(1'b0);
    send_tx();
    reset = 1'b1;
    #1;
    vectors++;
    if (crc_o !== 8'h00 || busy_o !== 1'b0 || we_o !== 4'h0 || data_o !== 32'h0 ||
        byte_ready_o !== 1'b0 || crc_valid_o !== 1'b0) begin
      miscompares++;
      $display("FAIL midreset crc %h busy %b we %b data %h ready %b cv %b want all 0",
               crc_o, busy_o, we_o, data_o, byte_ready_o, crc_valid_o);
    end
    @(negedge clk) reset = 1'b0;
    @(posedge clk); #1;
    vectors++;
    if (crc_q.size() !== 0) begin
      miscompares++; $display("FAIL midreset_pulse got %0d want 0", crc_q.size());
    end
    add_frame(8'h01, 1);
    send_tx();
    wait_crc(1);
    check_word(0, 32'h00000701, 4'b0011);
    vectors++;
    if (crc_o !== 8'h07) begin
      miscompares++; $display("FAIL after_reset_crc got %h want 07", crc_o);
    end
  endtask

  task automatic test_back_to_back();
    clear_logs();
    add_frame(8'h01, 3);
    add_frame(8'h01, 1);
    add_frame(8'h01, 4);
    send_tx();
    wait_crc(3);
    check_word(0, 32'h48030201, 4'hF);
    check_word(1, 32'h00000701, 4'b0011);
    check_word(2, 32'h04030201, 4'hF);
    check_word(3, 32'h000000E3, 4'b0001);
    vectors++;
    if (word_q.size() !== 4) begin
      miscompares++; $display("FAIL b2b_words got %0d want 4", word_q.size());
    end
    vectors++;
    if (crc_q.size() !== 3 || crc_q[0] !== 8'h48 || crc_q[1] !== 8'h07 || crc_q[2] !== 8'hE3) begin
      miscompares++; $display("FAIL b2b_crcs count %0d want 48,07,e3", crc_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_frame3();
    test_frame4();
    test_check_string();
    test_stall();
    test_reset_mid();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
